// File: rtl/mul_int_seq_if.sv
// Handshake bundle for mul_int_seq: request (in_*, A, B), response (out_*, P), status.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high;
// the sender holds its data steady while valid is high and ready is low.
interface mul_int_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] P;
   logic             busy;
   logic [1:0]       fsm_state;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, P, busy, fsm_state
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, P, busy, fsm_state
   );
endinterface

// File: rtl/mul_int_seq.sv
// Shift-and-add multiplier: one conditional add per clock, WIDTH steps, low WIDTH bits of A*B.
// Fixed latency; the result is held in P until the consumer takes it and kept afterwards.
module mul_int_seq #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   mul_int_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] acc_sum;

   // Carry out of the add is dropped: only the low WIDTH bits of the product are kept.
   assign acc_sum = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         p_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  mcand  <= bus.A;
                  mplier <= bus.B;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // No early exit on mplier==0, so latency never depends on operands.
               if (cnt == LAST) begin
                  p_q   <= acc_sum;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE) && !rst;
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state == S_RUN) || (state == S_DONE);
   assign bus.P         = p_q;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_mul_int_seq.sv
// Self-checking bench for mul_int_seq: WIDTH=8 directed and random operations, WIDTH=2 exhaustive.
module tb_mul_int_seq;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [31:0] exp_q[$];

   mul_int_seq_if #(.WIDTH(8)) bus8 ();
   mul_int_seq_if #(.WIDTH(2)) bus2 ();

   mul_int_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   mul_int_seq #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input int unsigned a, input int unsigned b, input int w);
      longint unsigned prod;
      prod = longint'(a) * longint'(b);
      return 32'(prod % (64'd1 << w));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation: accept, optional operand churn during RUN, optional stall in DONE.
   task automatic do_op8(input int unsigned a, input int unsigned b, input int stall, input bit churn);
      int lat;
      logic [31:0] exp;
      @(negedge clk);
      bus8.A = 8'(a);
      bus8.B = 8'(b);
      bus8.in_valid = 1'b1;
      bus8.out_ready = 1'b0;
      exp_q.push_back(ref_mul(a, b, 8));
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      check("accept_in_ready", bus8.in_ready, 0);
      check("accept_busy", bus8.busy, 1);
      lat = 0;
      while (!bus8.out_valid && lat < 40) begin
         if (churn) begin
            bus8.A = 8'($urandom_range(0, 255));
            bus8.B = 8'($urandom_range(0, 255));
            bus8.in_valid = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         lat++;
      end
      bus8.in_valid = 1'b0;
      check("latency8", lat, 8);
      exp = exp_q.pop_front();
      for (int s = 0; s < stall; s++) begin
         bus8.A = 8'($urandom_range(0, 255));
         bus8.B = 8'($urandom_range(0, 255));
         bus8.in_valid = 1'b1;
         check("stall_valid", bus8.out_valid, 1);
         check("stall_p", bus8.P, exp);
         @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1;
      check("done_valid", bus8.out_valid, 1);
      check("done_p", bus8.P, exp);
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      check("after_valid", bus8.out_valid, 0);
      check("after_in_ready", bus8.in_ready, 1);
      check("after_busy", bus8.busy, 0);
      check("after_p_hold", bus8.P, exp);
   endtask

   task automatic do_op2(input int unsigned a, input int unsigned b);
      int lat;
      @(negedge clk);
      bus2.A = 2'(a);
      bus2.B = 2'(b);
      bus2.in_valid = 1'b1;
      bus2.out_ready = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      lat = 0;
      while (!bus2.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency2", lat, 2);
      check("p2", bus2.P, ref_mul(a, b, 2));
      @(posedge clk); #1;
      check("after2_valid", bus2.out_valid, 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.out_ready = 1'b0;
      bus2.in_valid = 1'b0; bus2.A = '0; bus2.B = '0; bus2.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus8.in_ready, 0);
      check("rst_out_valid", bus8.out_valid, 0);
      check("rst_busy", bus8.busy, 0);
      check("rst_p", bus8.P, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_in_ready", bus8.in_ready, 1);

      do_op8(13, 11, 0, 0);
      do_op8(255, 255, 0, 0);
      do_op8(0, 200, 0, 0);
      do_op8(7, 9, 5, 0);
      do_op8(37, 201, 0, 1);

      // Asynchronous reset between edges 3 and 4 of a run.
      @(negedge clk);
      bus8.A = 8'd100;
      bus8.B = 8'd3;
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", bus8.in_ready, 0);
      check("midrst_out_valid", bus8.out_valid, 0);
      check("midrst_busy", bus8.busy, 0);
      check("midrst_p", bus8.P, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_rel_ready", bus8.in_ready, 1);
      do_op8(5, 6, 0, 0);

      for (int i = 0; i < 20; i++) begin
         do_op8($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            do_op2(a, b);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mul_int_seq.md
# mul_int_seq

Sequential shift-and-add integer multiplier controller. It sequences one WIDTH-bit add per clock to produce the lower WIDTH bits of A*B, which is the same function as the combinational multiplier, over WIDTH cycles. It sits in the misc arithmetic library as the area-minimal, multi-cycle alternative to the combinational `multiplier_nbit` path. Both its input and its output use a valid/ready handshake, so it can be dropped between pipeline stages.

## Interface
- WIDTH, 8, operand and product width in bits (≥2).
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  A/B present a request.
- in_ready  output  1  block can accept a request (IDLE only).
- A  input  WIDTH  multiplicand, unsigned (two's-complement low bits are identical).
- B  input  WIDTH  multiplier.
- out_valid  output  1  P holds a finished result.
- out_ready  input  1  consumer takes P.
- P  output  WIDTH  lower WIDTH bits of A*B, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states and transitions:
  - IDLE → RUN on accept (in_valid && in_ready).
  - RUN → DONE when the step counter reaches WIDTH steps.
  - DONE → IDLE on out_valid && out_ready.
- Registers: mcand (WIDTH), mplier (WIDTH), acc (WIDTH), cnt (clog2(WIDTH+1)), state.
- On accept:
  - mcand ← A, mplier ← B, acc ← 0, cnt ← 0.
  - A and B are sampled only at the accept edge. Later changes on A/B are ignored.
- Each RUN cycle:
  - if mplier[0], acc ← acc + mcand, truncated mod 2^WIDTH; carry-out is discarded;
  - mcand ← mcand << 1, zero-filled; mplier ← mplier >> 1; cnt ← cnt+1.
  - After the step that brings cnt to WIDTH: P ← final acc value, state ← DONE.
- Fixed latency. There is no early termination when mplier becomes 0.
- DONE:
  - out_valid=1; P is held stable until the handshake completes.
  - P keeps its last value after DONE exits; it changes only at the next completion.
- in_ready = (state==IDLE) && !rst, combinational from state. in_valid in RUN/DONE is ignored and the request is not queued.
- Outputs out_valid and busy decode from state. No combinational path from in_valid or out_ready to any output.
- Reset, asynchronous, any state including mid-RUN:
  - state ← IDLE; acc, mcand, mplier, cnt, P ← 0.
  - The operation in flight is dropped and no result is produced.
- Reset values: in_ready=0 while rst high, 1 in the first cycle after release; out_valid=0; busy=0; P=0.

## Timing
- Accept edge is edge 0. RUN performs steps on edges 1..WIDTH, and out_valid is high from just after edge WIDTH.
- Result latency: WIDTH cycles from the accept edge to out_valid.
- Back-to-back throughput, with out_ready held high: one result per WIDTH+2 cycles (1 IDLE + WIDTH RUN + 1 DONE).
- out_ready low in DONE: stall indefinitely. out_valid and P stay constant; no other state changes.
- in_valid low in IDLE: remain in IDLE. Registers other than P are don't-care there.
- rst asserted on the same edge as an accept or a DONE handshake: reset wins; the block stays in IDLE, out_valid=0, P=0.

## Test plan
- WIDTH=8, A=13, B=11, out_ready=1:
  - in_ready drops after accept; out_valid rises exactly 8 cycles after the accept edge;
  - P=0x8F (143) for one cycle, then back to IDLE.
- WIDTH=8, A=255, B=255 → P=0x01 (65025 mod 256), which checks truncation. Then A=0, B=200 → P=0 after the full 8-cycle latency, which checks there is no early exit.
- Backpressure: WIDTH=8, A=7, B=9 with out_ready=0 for 5 cycles after out_valid:
  - P=63 and out_valid held for all 5 cycles;
  - in_valid=1 with new operands during the stall is not accepted;
  - result consumed on the first out_ready=1 cycle.
- Reset mid-operation: WIDTH=8, A=100, B=3. Assert rst asynchronously between edges 3 and 4 (not on an edge).
  - Outputs go to in_ready=0, out_valid=0, busy=0, P=0 immediately.
  - After release, the next request A=5, B=6 yields P=30 with normal latency.
- Operand hold: change A/B every cycle during RUN → the result uses only the values present at the accept edge.
- WIDTH=2, exhaustive 16 pairs:
  - each P equals (A*B) mod 4, e.g. 3*3 → 1, 2*2 → 0, 3*2 → 2;
  - latency is 2 cycles;
  - results match the combinational 2-bit multiplier.
